// File: rtl/guard_pkg.sv
// Types shared by the AXI guard blocks: cause bit positions and snooped read-channel structs.
package guard_pkg;

  typedef enum logic [1:0] {
    CAUSE_TIMEOUT  = 2'd0,
    CAUSE_OVERFLOW = 2'd1,
    CAUSE_UNEXP_R  = 2'd2
  } rd_cause_e;

  typedef logic [3:0] axi_id_t;

  typedef struct packed {
    axi_id_t id;
  } ar_chan_t;

  typedef struct packed {
    axi_id_t id;
    logic    last;
  } r_chan_t;

  typedef struct packed {
    logic     ar_valid;
    ar_chan_t ar;
    logic     r_ready;
  } rd_req_t;

  typedef struct packed {
    logic    ar_ready;
    logic    r_valid;
    r_chan_t r;
  } rd_rsp_t;

endpackage

// File: rtl/rd_entry_counter.sv
// One tracking-table slot: owns an ID, its outstanding read count and the budget countdown.
module rd_entry_counter #(
  parameter int IdW      = 4,
  parameter int NumW     = 4,
  parameter int CntWidth = 10
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush,
  input  logic                hold,
  input  logic                tick,
  input  logic                alloc,
  input  logic                inc,
  input  logic                dec,
  input  logic [IdW-1:0]      id_in,
  input  logic [CntWidth-1:0] budget,
  output logic                free,
  output logic [IdW-1:0]      id,
  output logic [NumW-1:0]     num_txn,
  output logic                timeout
);

  typedef struct packed {
    logic                free;
    logic [IdW-1:0]      id;
    logic [NumW-1:0]     num_txn;
    logic [CntWidth-1:0] cnt;
  } id_track_t;

  localparam id_track_t TrackIdle = '{free: 1'b1, id: '0, num_txn: '0, cnt: '0};

  id_track_t q;

  assign free    = q.free;
  assign id      = q.id;
  assign num_txn = q.num_txn;
  assign timeout = !q.free && (q.cnt == '0);

  // An expiring entry is released even if it is hit by a handshake in the same cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q <= TrackIdle;
    end else if (flush || (!hold && timeout)) begin
      q <= TrackIdle;
    end else if (!hold) begin
      if (alloc) begin
        q.free    <= 1'b0;
        q.id      <= id_in;
        q.num_txn <= NumW'(1);
        q.cnt     <= budget;
      end else if (!q.free) begin
        if (dec && inc) begin
          q.cnt <= budget;
        end else if (dec) begin
          if (q.num_txn == NumW'(1)) begin
            q <= TrackIdle;
          end else begin
            q.num_txn <= q.num_txn - NumW'(1);
            q.cnt     <= budget;
          end
        end else begin
          if (inc) q.num_txn <= q.num_txn + NumW'(1);
          if (tick && q.cnt != '0) q.cnt <= q.cnt - CntWidth'(1);
        end
      end
    end
  end

endmodule

// File: rtl/read_guard.sv
// Passive AXI read watchdog: snoops AR/R handshakes, times outstanding reads per ID,
// and raises sticky irq / reset request on timeout, table overflow or unexpected R.
module read_guard
  import guard_pkg::*;
#(
  parameter int  MaxUniqIds   = 4,
  parameter int  MaxRdTxns    = 8,
  parameter int  PrescalerDiv = 1,
  parameter int  CntWidth     = 10,
  parameter type id_t         = axi_id_t,
  parameter type req_t        = rd_req_t,
  parameter type rsp_t        = rd_rsp_t
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                rd_en_i,
  input  logic [CntWidth-1:0] budget_i,
  input  req_t                mst_req_i,
  input  rsp_t                slv_rsp_i,
  input  logic                reset_clear_i,
  output logic                reset_req_o,
  output logic                irq_o,
  output logic [2:0]          irq_cause_o,
  output id_t                 err_id_o
);

  localparam int IdCap = (MaxUniqIds < MaxRdTxns) ? MaxUniqIds : MaxRdTxns;
  localparam int IW    = (IdCap > 1) ? $clog2(IdCap) : 1;
  localparam int NumW  = $clog2(MaxRdTxns + 1);
  localparam int IdW   = $bits(id_t);
  localparam int PW    = (PrescalerDiv > 1) ? $clog2(PrescalerDiv) : 1;

  function automatic logic [IW-1:0] lzc(input logic [IdCap-1:0] v);
    lzc = '0;
    for (int i = IdCap - 1; i >= 0; i--) if (v[i]) lzc = IW'(i);
  endfunction

  function automatic logic [IW-1:0] onehot_to_bin(input logic [IdCap-1:0] oh);
    onehot_to_bin = '0;
    for (int i = 0; i < IdCap; i++) if (oh[i]) onehot_to_bin |= IW'(i);
  endfunction

  logic [PW-1:0] pcnt_q;
  logic          tick, frozen, ar_act, rl_act, same, full, ovf, unexp;
  logic [IdCap-1:0] free, ar_hit, rl_hit, inc, dec, alloc, tmo_raw, tmo;
  logic [IdCap-1:0][IdW-1:0]  ent_id;
  logic [IdCap-1:0][NumW-1:0] ent_num;
  logic [IW-1:0] free_idx, ar_idx, tmo_idx;
  logic [2:0]    cause_q, new_cause;
  id_t           err_id_q, err_id_d, ar_id, r_id;

  assign tick = (pcnt_q == PW'(PrescalerDiv - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      pcnt_q <= '0;
    else if (reset_clear_i || tick)   pcnt_q <= '0;
    else                              pcnt_q <= pcnt_q + PW'(1);
  end

  // A pending timeout freezes the whole block until software clears it.
  assign frozen = cause_q[CAUSE_TIMEOUT];
  assign ar_id  = mst_req_i.ar.id;
  assign r_id   = slv_rsp_i.r.id;
  assign ar_act = mst_req_i.ar_valid & slv_rsp_i.ar_ready & rd_en_i & ~frozen & ~reset_clear_i;
  assign rl_act = slv_rsp_i.r_valid & mst_req_i.r_ready & slv_rsp_i.r.last & ~frozen & ~reset_clear_i;

  assign full     = ~|free;
  assign free_idx = lzc(free);
  assign ar_idx   = onehot_to_bin(ar_hit);
  assign tmo      = tmo_raw & {IdCap{~frozen}};
  assign tmo_idx  = lzc(tmo);
  // AR and R-last on the same tracked ID cancel out: count unchanged, budget restarts.
  assign same     = ar_act & rl_act & (ar_id == r_id) & (|rl_hit);

  assign ovf   = ar_act & ~same &
                 ((|ar_hit) ? (ent_num[ar_idx] == NumW'(MaxRdTxns)) : full);
  assign unexp = rl_act & ~(|rl_hit);

  for (genvar i = 0; i < IdCap; i++) begin : g_ent
    assign ar_hit[i] = ~free[i] & (ent_id[i] == ar_id);
    assign rl_hit[i] = ~free[i] & (ent_id[i] == r_id);
    assign inc[i]    = ar_act & ar_hit[i] & (same | (ent_num[i] < NumW'(MaxRdTxns)));
    assign dec[i]    = rl_act & rl_hit[i];
    assign alloc[i]  = ar_act & ~(|ar_hit) & ~full & (free_idx == IW'(i));

    rd_entry_counter #(
      .IdW      (IdW),
      .NumW     (NumW),
      .CntWidth (CntWidth)
    ) u_entry (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .flush   (reset_clear_i),
      .hold    (frozen),
      .tick    (tick & rd_en_i),
      .alloc   (alloc[i]),
      .inc     (inc[i]),
      .dec     (dec[i]),
      .id_in   (ar_id),
      .budget  (budget_i),
      .free    (free[i]),
      .id      (ent_id[i]),
      .num_txn (ent_num[i]),
      .timeout (tmo_raw[i])
    );
  end

  always_comb begin
    new_cause                 = '0;
    new_cause[CAUSE_TIMEOUT]  = |tmo;
    new_cause[CAUSE_OVERFLOW] = ovf;
    new_cause[CAUSE_UNEXP_R]  = unexp;
    err_id_d                  = err_id_q;
    if (cause_q == '0 && new_cause != '0) begin
      if (|tmo)     err_id_d = ent_id[tmo_idx];
      else if (ovf) err_id_d = ar_id;
      else          err_id_d = r_id;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cause_q  <= '0;
      err_id_q <= '0;
    end else if (reset_clear_i) begin
      cause_q  <= '0;
      err_id_q <= '0;
    end else begin
      cause_q  <= cause_q | new_cause;
      err_id_q <= err_id_d;
    end
  end

  assign irq_cause_o = cause_q;
  assign reset_req_o = cause_q[CAUSE_TIMEOUT];
  assign irq_o       = |cause_q;
  assign err_id_o    = err_id_q;

endmodule
